lc3_ctrl: RTL and testbench
===========================

LC3_CTRL -- requirements
Module: lc3_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: run  in  1  level; 1 = sequence instructions, 0 = stop at instruction boundary.
REQ-004 SHALL have: mem_rdata  in  16  memory read data.
REQ-005 SHALL have: mem_rvalid  in  1  memory response (read data valid / write ack), variable latency >= 1 cycle.
REQ-006 SHALL have: mem_req  out  1  memory access request, held until mem_rvalid.
REQ-007 SHALL have: mem_we  out  1  write qualifier for mem_req (stores only).
REQ-008 SHALL have: fetch_start  out  1  one-cycle pulse to fetch unit to advance PC.
REQ-009 SHALL have: ir  out  16  instruction register; opcode  out  4  equal to ir[15:12].
REQ-010 SHALL have: decode_en, exec_en, wb_en  out  1 each  one-cycle phase strobes.
REQ-011 SHALL have: halted  out  1  sticky halt; illegal  out  1  sticky illegal-opcode flag.
REQ-012 SHALL have: instr_cnt  out  16  retired-instruction counter.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_IR, DECODE, EXEC, MEM, WAIT_MEM, WB, NEXT, HALT.
REQ-014 IDLE -> FETCH when run=1; else stay; all strobes 0.
REQ-015 FETCH: mem_req=1, mem_we=0; -> WAIT_IR next cycle.
REQ-016 WAIT_IR: mem_req=1; on mem_rvalid latch mem_rdata into ir, -> DECODE; else stay.
REQ-017 DECODE: decode_en=1 one cycle; ir=xF025 (TRAP HALT) -> HALT; opcode 1000 or 1101 -> set illegal, -> HALT; else -> EXEC.
REQ-018 EXEC: exec_en=1 one cycle; LD/LDR/LDI/ST/STR/STI (0010,0110,1010,0011,0111,1011) -> MEM; ADD/AND/NOT/LEA/JSR (0001,0101,1001,1110,0100) -> WB; BR/JMP/other TRAP (0000,1100,1111) -> NEXT.
REQ-019 MEM: mem_req=1; mem_we=1 only for ST/STR, or STI second access; -> WAIT_MEM.
REQ-020 WAIT_MEM: mem_req and mem_we held; on mem_rvalid: LDI/STI first access -> set ind flag, -> MEM; loads -> WB; stores -> NEXT.
REQ-021 WB: wb_en=1 one cycle; -> NEXT.
REQ-022 NEXT: fetch_start=1 one cycle, instr_cnt+1 (wraps xFFFF->x0000), clear ind flag; -> FETCH if run=1, else IDLE.
REQ-023 HALT: terminal; fetch_start, mem_req, strobes 0; exit only via rst.
REQ-024 run deasserted mid-instruction SHALL NOT abort; instruction completes through NEXT.
REQ-025 mem_rvalid outside WAIT_IR/WAIT_MEM SHALL be ignored.
REQ-026 fetch_start SHALL never assert outside NEXT; at most one pulse per instruction.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, ir=x0000, instr_cnt=x0000, ind flag, halted, illegal and all outputs 0, regardless of state or pending memory access.
REQ-028 First FETCH after rst release SHALL occur on the first rising edge with run=1.

Structure
REQ-029 Opcode constants, TRAP HALT vector xF025 and state encoding SHALL live in shared package lc3_pkg.
REQ-030 Opcode classification (is_load, is_store, is_indirect, is_wb, is_illegal) SHALL be one combinational sub-module lc3_opclass.
REQ-031 All outputs SHALL be registered or decoded from the state register only; no combinational path mem_rvalid -> outputs.

Verification
REQ-032 rst=1 for 5 cycles, run=0, then rst=0 -> fetch_start=0, mem_req=0, ir=x0000, instr_cnt=0, state IDLE indefinitely.
REQ-033 run=1, mem returns x1261 after 2 cycles -> ir=x1261, decode_en, exec_en, wb_en, fetch_start each exactly one pulse, instr_cnt=1.
REQ-034 LDI xA002 -> two read mem_req transactions, mem_we=0 both, then wb_en, fetch_start; instr_cnt=1.
REQ-035 STR x7042 then STI xB003 -> STR: one request with mem_we=1, no wb_en; STI: read then write (mem_we=1), no wb_en.
REQ-036 ir=xF025 -> halted=1, no further mem_req or fetch_start for 50 cycles; ir=x8000 -> illegal=1, halted=1.
REQ-037 rst asserted during WAIT_MEM -> all outputs 0 same cycle; run dropped during EXEC -> instruction retires, then IDLE, no new FETCH.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 controller definitions.
// Opcodes, the HALT trap word, controller states and the opcode class bundle.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [15:0] TRAP_HALT = 16'hF025;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_IR,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WAIT_MEM,
    S_WB,
    S_NEXT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_indirect;
    logic is_wb;
    logic is_illegal;
  } opclass_t;

endpackage

// File: rtl/lc3_opclass.sv
// LC-3 opcode classifier.
// Pure combinational grouping of the 4-bit opcode.
module lc3_opclass
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_LD, OP_LDR: cls.is_load = 1'b1;
      OP_LDI: begin
        cls.is_load     = 1'b1;
        cls.is_indirect = 1'b1;
      end
      OP_ST, OP_STR: cls.is_store = 1'b1;
      OP_STI: begin
        cls.is_store    = 1'b1;
        cls.is_indirect = 1'b1;
      end
      OP_ADD, OP_AND, OP_NOT,
      OP_LEA, OP_JSR: cls.is_wb = 1'b1;
      OP_RTI, OP_RES: cls.is_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_ctrl.sv
// LC-3 multi-cycle instruction sequencer.
// Outputs are decoded from registered state only.
module lc3_ctrl
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_req,
  output logic        mem_we,
  output logic        fetch_start,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_cnt
);

  state_t   state, state_nx;
  logic     ind;
  opclass_t cls;

  assign opcode = ir[15:12];

  lc3_opclass u_opclass (
    .opcode(ir[15:12]),
    .cls   (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ir        <= 16'h0000;
      instr_cnt <= 16'h0000;
      ind       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT_IR && mem_rvalid)
        ir <= mem_rdata;
      // first half of LDI/STI fetched the pointer
      if (state == S_WAIT_MEM && mem_rvalid && cls.is_indirect)
        ind <= 1'b1;
      if (state == S_DECODE && ir != TRAP_HALT && cls.is_illegal)
        illegal <= 1'b1;
      if (state == S_NEXT) begin
        instr_cnt <= instr_cnt + 16'd1;
        ind       <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (run) state_nx = S_FETCH;
      S_FETCH:   state_nx = S_WAIT_IR;
      S_WAIT_IR: if (mem_rvalid) state_nx = S_DECODE;
      S_DECODE: begin
        if (ir == TRAP_HALT || cls.is_illegal)
          state_nx = S_HALT;
        else
          state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (cls.is_load || cls.is_store)
          state_nx = S_MEM;
        else if (cls.is_wb)
          state_nx = S_WB;
        else
          state_nx = S_NEXT;
      end
      S_MEM: state_nx = S_WAIT_MEM;
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          if (cls.is_indirect && !ind)
            state_nx = S_MEM;
          else if (cls.is_load)
            state_nx = S_WB;
          else
            state_nx = S_NEXT;
        end
      end
      S_WB:   state_nx = S_NEXT;
      S_NEXT: state_nx = run ? S_FETCH : S_IDLE;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  logic in_mem;
  assign in_mem = (state == S_MEM) || (state == S_WAIT_MEM);

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    fetch_start = 1'b0;
    decode_en   = 1'b0;
    exec_en     = 1'b0;
    wb_en       = 1'b0;
    halted      = 1'b0;
    unique case (1'b1)
      state == S_FETCH,
      state == S_WAIT_IR: mem_req = 1'b1;
      in_mem: begin
        mem_req = 1'b1;
        // STI reads its pointer before writing
        mem_we  = cls.is_store && (!cls.is_indirect || ind);
      end
      state == S_DECODE: decode_en   = 1'b1;
      state == S_EXEC:   exec_en     = 1'b1;
      state == S_WB:     wb_en       = 1'b1;
      state == S_NEXT:   fetch_start = 1'b1;
      state == S_HALT:   halted      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_ctrl.sv
// Self-checking bench for lc3_ctrl.
// Random-latency memory responder plus an instruction-level reference model.
module tb_lc3_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rvalid = 1'b0;
  logic        mem_req, mem_we, fetch_start;
  logic [15:0] ir, instr_cnt;
  logic [3:0]  opcode;
  logic        decode_en, exec_en, wb_en, halted, illegal;

  always #5 clk = ~clk;

  lc3_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .fetch_start(fetch_start),
    .ir         (ir),
    .opcode     (opcode),
    .decode_en  (decode_en),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .halted     (halted),
    .illegal    (illegal),
    .instr_cnt  (instr_cnt)
  );

  int checks = 0;
  int errors = 0;

  int n_dec = 0, n_exe = 0, n_wb = 0, n_fs = 0;
  bit we_log[$];
  logic [15:0] data_q[$];
  logic [15:0] prog[$];
  int lat_min = 1, lat_max = 3;

  always @(negedge clk) begin
    if (!rst) begin
      if (decode_en)   n_dec++;
      if (exec_en)     n_exe++;
      if (wb_en)       n_wb++;
      if (fetch_start) n_fs++;
    end
  end

  // memory: one response per request, 1..lat_max cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        we_log.push_back(mem_we);
        repeat ($urandom_range(lat_max, lat_min)) @(posedge clk);
        #1;
        mem_rdata  = (data_q.size() > 0) ? data_q.pop_front()
                                         : 16'($urandom);
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
      end
    end
  end

  // instruction-level reference: data accesses and effects
  task automatic model(input logic [15:0] i, output int nd,
                       output bit w0, output bit w1, output bit wb,
                       output bit stop, output bit ill);
    logic [3:0] op;
    op = i[15:12];
    nd = 0; w0 = 0; w1 = 0; wb = 0; stop = 0; ill = 0;
    if (i == 16'hF025) stop = 1;
    else if (op == 4'h8 || op == 4'hD) begin
      stop = 1; ill = 1;
    end else begin
      case (op)
        4'h2, 4'h6: begin nd = 1; wb = 1; end
        4'hA:       begin nd = 2; wb = 1; end
        4'h3, 4'h7: begin nd = 1; w0 = 1; end
        4'hB:       begin nd = 2; w1 = 1; end
        4'h1, 4'h5, 4'h9,
        4'hE, 4'h4: wb = 1;
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] rand_legal();
    logic [15:0] v;
    do v = 16'($urandom);
    while (v[15:12] == 4'h8 || v[15:12] == 4'hD || v == 16'hF025);
    return v;
  endfunction

  int b_dec, b_exe, b_wb, b_fs, b_we;
  int d_dec, d_exe, d_wb, d_fs;
  logic [63:0] e_we, g_we;
  int e_n, g_n, e_wb, e_cnt, e_dec;
  bit e_halt, e_ill;
  logic [15:0] e_ir;

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    run = 1'b0;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    data_q.delete();
  endtask

  task automatic run_prog(input bit drop_run);
    int nd, lim;
    bit w0, w1, wb, stop, ill, tmo;
    b_dec = n_dec; b_exe = n_exe; b_wb = n_wb; b_fs = n_fs;
    b_we = we_log.size();
    e_we = '0; e_n = 0; e_wb = 0; e_cnt = 0; e_dec = 0;
    e_halt = 0; e_ill = 0; e_ir = 16'h0;
    lim = drop_run ? 1 : prog.size();
    for (int k = 0; k < lim; k++) begin
      model(prog[k], nd, w0, w1, wb, stop, ill);
      data_q.push_back(prog[k]);
      e_dec++;
      e_ir = prog[k];
      e_n++;
      if (stop) begin
        e_halt = 1; e_ill = ill;
        break;
      end
      for (int d = 0; d < nd; d++) begin
        data_q.push_back(16'($urandom));
        e_we[e_n] = (d == 0) ? w0 : w1;
        e_n++;
      end
      e_wb += int'(wb);
      e_cnt++;
    end
    @(negedge clk);
    run = 1'b1;
    tmo = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (drop_run && exec_en) run = 1'b0;
      if (halted || (drop_run && fetch_start)) begin
        tmo = 0;
        break;
      end
    end
    run = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL run_timeout: no completion, required retire or halt");
    end
    d_dec = n_dec - b_dec; d_exe = n_exe - b_exe;
    d_wb = n_wb - b_wb;    d_fs = n_fs - b_fs;
    g_n = we_log.size() - b_we;
    g_we = '0;
    for (int k = 0; k < g_n && k < 64; k++) g_we[k] = we_log[b_we + k];
  endtask

  task automatic test_reset();
    int seen;
    do_reset(5);
    seen = 0;
    repeat (30) @(negedge clk)
      if (mem_req | mem_we | fetch_start | decode_en | exec_en | wb_en)
        seen++;
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_idle: %0d active cycles, required 0", seen);
    end
    checks++;
    if (ir !== 16'h0 || opcode !== 4'h0) begin
      errors++; $display("FAIL reset_ir: got %h, required 0000", ir);
    end
    checks++;
    if (instr_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h, required 0000", instr_cnt);
    end
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got %b%b, required 00", halted, illegal);
    end
  endtask

  task automatic test_add();
    do_reset(15);
    prog = '{16'h1261};
    run_prog(1);
    checks++;
    if (ir !== 16'h1261 || opcode !== 4'h1) begin
      errors++; $display("FAIL add_ir: got %h, required 1261", ir);
    end
    checks++;
    if (d_dec !== 1 || d_exe !== 1 || d_wb !== 1 || d_fs !== 1) begin
      errors++;
      $display("FAIL add_pulses: got d%0d e%0d w%0d f%0d, required 1 each",
               d_dec, d_exe, d_wb, d_fs);
    end
    checks++;
    if (instr_cnt !== 16'd1) begin
      errors++; $display("FAIL add_cnt: got %0d, required 1", instr_cnt);
    end
    checks++;
    if (g_n !== 1 || g_we !== e_we) begin
      errors++; $display("FAIL add_mem: got %0d acc, required 1", g_n);
    end
  endtask

  task automatic test_ldi();
    do_reset(15);
    prog = '{16'hA002};
    run_prog(1);
    checks++;
    if (g_n !== 3 || g_we !== 64'h0) begin
      errors++;
      $display("FAIL ldi_mem: got %0d acc we=%h, required 3 reads", g_n, g_we);
    end
    checks++;
    if (d_wb !== 1 || d_fs !== 1 || instr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ldi_retire: got wb%0d fs%0d cnt%0d, required 1 1 1",
               d_wb, d_fs, instr_cnt);
    end
  endtask

  task automatic test_str_sti();
    do_reset(15);
    prog = '{16'h7042, 16'hB003, 16'hF025};
    run_prog(0);
    checks++;
    if (g_n !== 6 || g_we !== 64'b010010) begin
      errors++;
      $display("FAIL store_mem: got %0d acc we=%b, required 6 we=010010",
               g_n, g_we[5:0]);
    end
    checks++;
    if (d_wb !== 0 || d_fs !== 2 || instr_cnt !== 16'd2) begin
      errors++;
      $display("FAIL store_retire: got wb%0d fs%0d cnt%0d, required 0 2 2",
               d_wb, d_fs, instr_cnt);
    end
  endtask

  task automatic test_halt(input logic [15:0] instr, input bit ill);
    int seen;
    do_reset(15);
    prog = '{instr};
    run_prog(0);
    seen = 0;
    run = 1'b1;
    repeat (50) @(negedge clk) if (mem_req | fetch_start) seen++;
    run = 1'b0;
    checks++;
    if (halted !== 1'b1 || illegal !== ill) begin
      errors++;
      $display("FAIL halt_flags %h: got h%b i%b, required h1 i%b",
               instr, halted, illegal, ill);
    end
    checks++;
    if (seen !== 0 || d_fs !== 0) begin
      errors++;
      $display("FAIL halt_quiet %h: %0d active, required 0", instr, seen);
    end
    checks++;
    if (instr_cnt !== 16'd0 || ir !== instr) begin
      errors++;
      $display("FAIL halt_state %h: cnt %0d ir %h, required 0 %h",
               instr, instr_cnt, ir, instr);
    end
  endtask

  task automatic test_rst_mid();
    bit tmo;
    do_reset(15);
    lat_min = 6; lat_max = 6;
    data_q.push_back(16'h3001);
    data_q.push_back(16'h1234);
    @(negedge clk);
    run = 1'b1;
    tmo = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exec_en) begin tmo = 0; break; end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tmo || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got req%b we%b, required 1 1", mem_req, mem_we);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, fetch_start, decode_en, exec_en, wb_en,
         halted, illegal} !== 8'h0 || ir !== 16'h0 || instr_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_out: outputs not cleared, ir %h cnt %h", ir, instr_cnt);
    end
    run = 1'b0;
    lat_min = 1; lat_max = 3;
    do_reset(15);
  endtask

  task automatic test_run_drop();
    int seen;
    do_reset(15);
    prog = '{16'h6283};
    run_prog(1);
    seen = 0;
    repeat (20) @(negedge clk) if (mem_req | fetch_start) seen++;
    checks++;
    if (d_fs !== 1 || instr_cnt !== 16'd1 || d_wb !== 1) begin
      errors++;
      $display("FAIL drop_retire: got fs%0d cnt%0d wb%0d, required 1 1 1",
               d_fs, instr_cnt, d_wb);
    end
    checks++;
    if (seen !== 0 || g_n !== 2) begin
      errors++;
      $display("FAIL drop_idle: %0d active, %0d acc, required 0 2", seen, g_n);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      do_reset(15);
      lat_max = 1 + (it % 4);
      n = $urandom_range(8, 3);
      prog.delete();
      for (int k = 0; k < n; k++) prog.push_back(rand_legal());
      if (it % 3 == 2)
        prog.push_back({($urandom_range(1, 0) == 1) ? 4'h8 : 4'hD, 12'($urandom)});
      else
        prog.push_back(16'hF025);
      run_prog(0);
      checks++;
      if (g_n !== e_n || g_we !== e_we) begin
        errors++;
        $display("FAIL rand%0d_mem: got %0d acc we=%h, required %0d we=%h",
                 it, g_n, g_we, e_n, e_we);
      end
      checks++;
      if (d_dec !== e_dec || d_exe !== e_cnt || d_wb !== e_wb) begin
        errors++;
        $display("FAIL rand%0d_strobes: got d%0d e%0d w%0d, required %0d %0d %0d",
                 it, d_dec, d_exe, d_wb, e_dec, e_cnt, e_wb);
      end
      checks++;
      if (d_fs !== e_cnt || instr_cnt !== 16'(e_cnt)) begin
        errors++;
        $display("FAIL rand%0d_retire: got fs%0d cnt%0d, required %0d",
                 it, d_fs, instr_cnt, e_cnt);
      end
      checks++;
      if (halted !== e_halt || illegal !== e_ill || ir !== e_ir) begin
        errors++;
        $display("FAIL rand%0d_end: got h%b i%b ir %h, required h%b i%b ir %h",
                 it, halted, illegal, ir, e_halt, e_ill, e_ir);
      end
    end
    lat_max = 3;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldi();
    test_str_sti();
    test_halt(16'hF025, 1'b0);
    test_halt(16'h8000, 1'b1);
    test_rst_mid();
    test_run_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
